fb_write_arbiter: RTL and testbench
===================================

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, pixel colour width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 19, frame-buffer address width.
REQ-003 SHALL have parameter PIXELS, default 307200 (640x480), number of valid pixel addresses.
REQ-004 clk  input  1  sole clock; all logic on posedge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 brush_valid  input  1  brush write request.
REQ-007 brush_addr  input  ADDR_WIDTH  brush pixel address.
REQ-008 brush_color  input  DATA_WIDTH  brush pixel colour.
REQ-009 brush_ready  output  1  brush request accepted this cycle.
REQ-010 clear_start  input  1  single-cycle request to fill the whole frame.
REQ-011 clear_color  input  DATA_WIDTH  fill colour, sampled with clear_start.
REQ-012 busy  output  1  clear sweep in progress.
REQ-013 clear_done  output  1  one-cycle pulse after the last clear write.
REQ-014 addr_err  output  1  one-cycle pulse when an accepted brush address is >= PIXELS.
REQ-015 mem_addr  output  ADDR_WIDTH  RAM write-port address.
REQ-016 mem_wdata  output  DATA_WIDTH  RAM write-port data.
REQ-017 mem_cs, mem_we  output  1 each  RAM chip-select and write-enable, always equal.
REQ-018 mem_oe  output  1  tied 0 (write-only port).

Function
REQ-019 FSM states SHALL be IDLE and CLEAR.
REQ-020 brush_ready SHALL equal (state==IDLE) && !clear_start.
REQ-021 Brush handshake: a transfer occurs when brush_valid && brush_ready; mem_addr/mem_wdata/mem_cs/mem_we SHALL present that write exactly 1 cycle later (registered).
REQ-022 An accepted brush address >= PIXELS SHALL produce no RAM write (mem_cs=0) and addr_err=1 in the cycle the write would have issued.
REQ-023 clear_start in IDLE SHALL latch clear_color, clear the sweep counter to 0 and enter CLEAR next cycle; it takes priority over a simultaneous brush_valid, which is not accepted.
REQ-024 In CLEAR, each cycle SHALL issue one write of the latched colour at the counter address (0, 1, ..., PIXELS-1), counter incrementing by 1.
REQ-025 The write to address PIXELS-1 SHALL be the last one; in the following cycle: clear_done=1, state=IDLE, busy=0, mem_cs=0; a sweep is exactly PIXELS write cycles.
REQ-026 busy SHALL be 1 in every cycle where state==CLEAR.
REQ-027 clear_start while in CLEAR SHALL be ignored (no restart, colour unchanged).
REQ-028 brush_valid during CLEAR SHALL be held off (brush_ready=0); brush requester holds addr/colour stable until ready.
REQ-029 Counter SHALL be ADDR_WIDTH bits; it never exceeds PIXELS-1, so no wrap occurs.
REQ-030 When no write issues, mem_cs=mem_we=0; mem_addr/mem_wdata hold their last values.

Reset
REQ-031 On rst_n=0, immediately: state=IDLE, counter=0, latched colour=0, mem_addr=0, mem_wdata=0, mem_cs=mem_we=0, clear_done=0, addr_err=0, busy=0.
REQ-032 Reset asserted mid-sweep SHALL abort the sweep with no clear_done; the pending brush write is discarded.
REQ-033 First brush acceptance possible on the first posedge after rst_n deasserts.

Structure
REQ-034 Shared package fb_pkg SHALL hold the FSM state enum, default widths and the PIXELS constant (640*480).
REQ-035 One sub-module fb_clear_sweep (counter plus last-address compare) SHALL be instantiated; everything else is in fb_write_arbiter.

Verification
REQ-036 Brush write addr=0x00100 colour=0xA in IDLE -> brush_ready=1; next cycle mem_cs=mem_we=1, mem_addr=0x00100, mem_wdata=0xA.
REQ-037 clear_start colour=0x3 with PIXELS=16 override -> busy for 16 cycles, writes to addresses 0..15 all 0x3, clear_done pulses once, then IDLE.
REQ-038 clear_start and brush_valid in the same cycle -> brush_ready=0, clear wins; brush accepted the cycle after clear_done.
REQ-039 Brush addr=PIXELS (307200) -> accepted, no mem_cs, addr_err=1 one cycle later.
REQ-040 rst_n pulsed low mid-sweep at counter 7 -> all outputs 0 asynchronously, no clear_done, IDLE after release.
REQ-041 clear_start during CLEAR with colour 0xF -> ignored; remaining writes keep the original colour, single clear_done.

Source files
------------

// File: rtl/fb_pkg.sv
`default_nettype none
// fb_pkg: shared state encoding, default widths and frame geometry for the frame-buffer write path.
// Revision 1.0
package fb_pkg;

  localparam int unsigned c_FB_DATA_WIDTH = 4;
  localparam int unsigned c_FB_ADDR_WIDTH = 19;
  localparam int unsigned c_FB_H_PIXELS   = 640;
  localparam int unsigned c_FB_V_PIXELS   = 480;
  localparam int unsigned c_FB_PIXELS     = c_FB_H_PIXELS * c_FB_V_PIXELS;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } fb_state_e;

endpackage
`default_nettype wire

// File: rtl/fb_clear_sweep.sv
`default_nettype none
// fb_clear_sweep: sweep address counter for a full-frame clear, with last-address detect.
// Revision 1.0
module fb_clear_sweep
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = c_FB_ADDR_WIDTH,
  parameter int unsigned PIXELS     = c_FB_PIXELS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_step,
  output logic [ADDR_WIDTH-1:0] o_count_next,
  output logic                  o_last
);

  localparam logic [ADDR_WIDTH-1:0] c_LAST = ADDR_WIDTH'(PIXELS - 1);

  logic [ADDR_WIDTH-1:0] r_count;

  // Stepping stops at the last address, so the counter never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_start) begin
      r_count <= '0;
    end else if (i_step && !o_last) begin
      r_count <= o_count_next;
    end
  end

  assign o_count_next = r_count + ADDR_WIDTH'(1);
  assign o_last       = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/fb_write_arbiter.sv
`default_nettype none
// fb_write_arbiter: shares one frame-buffer RAM write port between a brush and a full-frame clear sweep.
// Revision 1.0
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = c_FB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = c_FB_ADDR_WIDTH,
  parameter int unsigned PIXELS     = c_FB_PIXELS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  brush_valid,
  input  logic [ADDR_WIDTH-1:0] brush_addr,
  input  logic [DATA_WIDTH-1:0] brush_color,
  output logic                  brush_ready,
  input  logic                  clear_start,
  input  logic [DATA_WIDTH-1:0] clear_color,
  output logic                  busy,
  output logic                  clear_done,
  output logic                  addr_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);

  // One extra bit keeps the range compare correct even if PIXELS == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] c_PIXELS_EXT = (ADDR_WIDTH + 1)'(PIXELS);

  fb_state_e             r_state;
  fb_state_e             w_state_next;
  logic                  w_clear_go;
  logic                  w_sweep_step;
  logic                  w_sweep_last;
  logic [ADDR_WIDTH-1:0] w_sweep_next;
  logic                  w_brush_fire;
  logic                  w_brush_in_range;

  logic [DATA_WIDTH-1:0] r_color;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_mem_cs;
  logic                  r_clear_done;
  logic                  r_addr_err;

  fb_clear_sweep #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PIXELS     (PIXELS)
  ) u_sweep (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (w_clear_go),
    .i_step       (w_sweep_step),
    .o_count_next (w_sweep_next),
    .o_last       (w_sweep_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_clear_go   = 1'b0;
    w_sweep_step = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clear_start) begin
          w_clear_go   = 1'b1;
          w_state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_sweep_step = 1'b1;
        if (w_sweep_last) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign brush_ready      = (r_state == ST_IDLE) && !clear_start;
  assign w_brush_fire     = brush_valid && brush_ready;
  assign w_brush_in_range = ({1'b0, brush_addr} < c_PIXELS_EXT);
  assign busy             = (r_state == ST_CLEAR);

  // The write port register runs one address ahead of the sweep counter so
  // each CLEAR cycle presents its own write and the cycle after the last one is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_color      <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_cs     <= 1'b0;
      r_clear_done <= 1'b0;
      r_addr_err   <= 1'b0;
    end else begin
      r_mem_cs     <= 1'b0;
      r_clear_done <= 1'b0;
      r_addr_err   <= 1'b0;
      if (w_clear_go) begin
        r_color     <= clear_color;
        r_mem_addr  <= '0;
        r_mem_wdata <= clear_color;
        r_mem_cs    <= 1'b1;
      end else if (r_state == ST_CLEAR) begin
        if (w_sweep_last) begin
          r_clear_done <= 1'b1;
        end else begin
          r_mem_addr  <= w_sweep_next;
          r_mem_wdata <= r_color;
          r_mem_cs    <= 1'b1;
        end
      end else if (w_brush_fire) begin
        if (w_brush_in_range) begin
          r_mem_addr  <= brush_addr;
          r_mem_wdata <= brush_color;
          r_mem_cs    <= 1'b1;
        end else begin
          r_addr_err <= 1'b1;
        end
      end
    end
  end

  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_cs     = r_mem_cs;
  assign mem_we     = r_mem_cs;
  assign mem_oe     = 1'b0;
  assign clear_done = r_clear_done;
  assign addr_err   = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// tb_fb_write_arbiter: scoreboard bench; a 16-pixel instance for sweeps and a full-size one for brush range checks.
module tb_fb_write_arbiter;

  localparam int AW      = 19;
  localparam int DW      = 4;
  localparam int SMALL_P = 16;

  typedef struct packed {
    logic          cs;
    logic          we;
    logic          oe;
    logic          err;
    logic          done;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          s_valid = 1'b0, s_start = 1'b0;
  logic [AW-1:0] s_baddr = '0;
  logic [DW-1:0] s_bcolor = '0, s_ccolor = '0;
  logic          s_ready, s_busy, s_done, s_err, s_cs, s_we, s_oe;
  logic [AW-1:0] s_maddr;
  logic [DW-1:0] s_wdata;

  logic          b_valid = 1'b0, b_start = 1'b0;
  logic [AW-1:0] b_baddr = '0;
  logic [DW-1:0] b_bcolor = '0, b_ccolor = '0;
  logic          b_ready, b_busy, b_done, b_err, b_cs, b_we, b_oe;
  logic [AW-1:0] b_maddr;
  logic [DW-1:0] b_wdata;

  fb_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PIXELS(SMALL_P)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .brush_valid(s_valid), .brush_addr(s_baddr), .brush_color(s_bcolor), .brush_ready(s_ready),
    .clear_start(s_start), .clear_color(s_ccolor),
    .busy(s_busy), .clear_done(s_done), .addr_err(s_err),
    .mem_addr(s_maddr), .mem_wdata(s_wdata), .mem_cs(s_cs), .mem_we(s_we), .mem_oe(s_oe)
  );

  fb_write_arbiter dut_big (
    .clk(clk), .rst_n(rst_n),
    .brush_valid(b_valid), .brush_addr(b_baddr), .brush_color(b_bcolor), .brush_ready(b_ready),
    .clear_start(b_start), .clear_color(b_ccolor),
    .busy(b_busy), .clear_done(b_done), .addr_err(b_err),
    .mem_addr(b_maddr), .mem_wdata(b_wdata), .mem_cs(b_cs), .mem_we(b_we), .mem_oe(b_oe)
  );

  ev_t q_s[$];
  ev_t q_b[$];
  int  n_vec = 0;
  int  n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ev_t mk(input logic cs, input logic we, input logic oe, input logic err,
                             input logic done, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ev_t e;
    e.cs = cs; e.we = we; e.oe = oe; e.err = err; e.done = done; e.addr = a; e.data = d;
    return e;
  endfunction

  function automatic ev_t wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    return mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a, d);
  endfunction

  // Error and done pulses carry the held (last written) address and data.
  function automatic ev_t er(input logic [AW-1:0] a, input logic [DW-1:0] d);
    return mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, a, d);
  endfunction

  function automatic ev_t dn(input logic [AW-1:0] a, input logic [DW-1:0] d);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, a, d);
  endfunction

  always @(negedge clk) begin
    ev_t a;
    a = mk(s_cs, s_we, s_oe, s_err, s_done, s_maddr, s_wdata);
    if (a.cs | a.we | a.oe | a.err | a.done) begin
      if (q_s.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL small_unexpected: got 0x%0h expected no event", a);
      end else begin
        check("small_event", a, q_s.pop_front());
      end
    end
    a = mk(b_cs, b_we, b_oe, b_err, b_done, b_maddr, b_wdata);
    if (a.cs | a.we | a.oe | a.err | a.done) begin
      if (q_b.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL big_unexpected: got 0x%0h expected no event", a);
      end else begin
        check("big_event", a, q_b.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_small_busy(output int n);
    n = 0;
    while (s_busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #12;
    check("small_reset", {s_busy, s_done, s_err, s_cs, s_we, s_oe, s_maddr, s_wdata}, '0);
    check("big_reset",   {b_busy, b_done, b_err, b_cs, b_we, b_oe, b_maddr, b_wdata}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Brush writes: in-range, at PIXELS, last valid pixel, top of address space.
    b_valid = 1'b1; b_baddr = 19'h00100; b_bcolor = 4'hA;
    s_valid = 1'b1; s_baddr = 19'd15;    s_bcolor = 4'h2;
    #1;
    check("big_ready_first",   b_ready, 1'b1);
    check("small_ready_first", s_ready, 1'b1);
    q_b.push_back(wr(19'h00100, 4'hA));
    q_s.push_back(wr(19'd15, 4'h2));
    tick();
    b_baddr = 19'd307200; b_bcolor = 4'h1;
    s_baddr = 19'd16;     s_bcolor = 4'h5;
    q_b.push_back(er(19'h00100, 4'hA));
    q_s.push_back(er(19'd15, 4'h2));
    tick();
    b_baddr = 19'd307199; b_bcolor = 4'h7;
    s_valid = 1'b0;
    q_b.push_back(wr(19'd307199, 4'h7));
    tick();
    b_baddr = 19'h7FFFF; b_bcolor = 4'h3;
    q_b.push_back(er(19'd307199, 4'h7));
    tick();
    b_valid = 1'b0;
    tick();

    // Full sweep; colour input changes after start must not matter.
    s_start = 1'b1; s_ccolor = 4'h3;
    for (int i = 0; i < SMALL_P; i++) q_s.push_back(wr(AW'(i), 4'h3));
    q_s.push_back(dn(19'd15, 4'h3));
    tick();
    s_start = 1'b0; s_ccolor = 4'h0;
    wait_small_busy(n);
    check("sweep_busy_cycles", n, 16);
    check("ready_after_sweep", s_ready, 1'b1);
    tick();

    // Clear and brush together: clear wins, brush waits for the end of the sweep.
    s_start = 1'b1; s_ccolor = 4'h5;
    s_valid = 1'b1; s_baddr = 19'd9; s_bcolor = 4'h9;
    #1;
    check("ready_low_on_start", s_ready, 1'b0);
    for (int i = 0; i < SMALL_P; i++) q_s.push_back(wr(AW'(i), 4'h5));
    q_s.push_back(dn(19'd15, 4'h5));
    q_s.push_back(wr(19'd9, 4'h9));
    tick();
    s_start = 1'b0;
    #1;
    check("ready_low_in_clear", s_ready, 1'b0);
    wait_small_busy(n);
    check("contend_busy_cycles", n, 16);
    check("ready_after_contend", s_ready, 1'b1);
    tick();
    s_valid = 1'b0;
    tick();

    // Restart attempt mid-sweep is ignored.
    s_start = 1'b1; s_ccolor = 4'h6;
    for (int i = 0; i < SMALL_P; i++) q_s.push_back(wr(AW'(i), 4'h6));
    q_s.push_back(dn(19'd15, 4'h6));
    tick();
    s_start = 1'b0;
    repeat (3) tick();
    s_start = 1'b1; s_ccolor = 4'hF;
    tick();
    s_start = 1'b0;
    wait_small_busy(n);
    check("restart_remaining_cycles", n, 12);
    tick();

    // Reset mid-sweep at counter 7.
    s_start = 1'b1; s_ccolor = 4'hC;
    for (int i = 0; i < 7; i++) q_s.push_back(wr(AW'(i), 4'hC));
    tick();
    s_start = 1'b0;
    repeat (7) tick();
    check("sweep_addr_before_reset", {s_busy, s_maddr}, {1'b1, 19'd7});
    rst_n = 1'b0;
    #1;
    check("small_async_reset", {s_busy, s_done, s_err, s_cs, s_we, s_oe, s_maddr, s_wdata}, '0);
    check("small_queue_drained", q_s.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_valid = 1'b1; s_baddr = 19'd4; s_bcolor = 4'hB;
    #1;
    check("ready_after_reset", {s_busy, s_ready}, 2'b01);
    q_s.push_back(wr(19'd4, 4'hB));
    tick();
    s_valid = 1'b0;
    repeat (4) tick();

    check("small_queue_empty", q_s.size(), 0);
    check("big_queue_empty",   q_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
